// File: rtl/logic_unit_pipe_if.sv
// Valid/ready stream bundle for the pipelined logic unit.
// master drives operands and out_ready; slave is the unit.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
  logic             out_par;

  modport master (
    output in_valid, in_a, in_b, in_op,
    output in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_zero, out_ones, out_par
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    input  in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data,
    output out_zero, out_ones, out_par
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with accumulator and result flags.
// Stage 1 holds the raw result, stage 2 the output with its flags.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_pipe_if.slave  bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zero;
  logic             s2_ones;
  logic             s2_par;
  logic [WIDTH-1:0] acc_q;

  logic             s2_free;
  logic             s1_move;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;

  assign s2_free = !s2_valid || bus.out_ready;
  assign s1_move = s1_valid && s2_free;
  assign ready   = !s1_valid || s2_free;
  assign accept  = bus.in_valid && ready;
  assign opb     = bus.in_acc ? acc_q : bus.in_b;

  always_comb begin
    res = '0;
    unique case (bus.in_op)
      3'b000: res = bus.in_a & opb;
      3'b001: res = bus.in_a | opb;
      3'b010: res = ~(bus.in_a | opb);
      3'b011: res = ~bus.in_a;
      3'b100: res = bus.in_a ^ opb;
      3'b101: res = ~(bus.in_a ^ opb);
      3'b110: res = ~(bus.in_a & opb);
      3'b111: res = bus.in_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= res;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Flags travel with the data so they never glitch on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= 1'b0;
      s2_ones  <= 1'b0;
      s2_par   <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      s2_data  <= s1_data;
      s2_zero  <= ~|s1_data;
      s2_ones  <= &s1_data;
      s2_par   <= ^s1_data;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Clear wins over an accumulating accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
    end else if (accept && bus.in_acc) begin
      acc_q <= res;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_zero  = s2_zero;
  assign bus.out_ones  = s2_ones;
  assign bus.out_par   = s2_par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed plan plus random traffic
// against a queue-based transaction model.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus ();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    int           age;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] macc = '0;
  logic [W-1:0] got[$];

  function automatic logic [W-1:0] gate(
    logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~a;
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~(a & b);
      default: return a;
    endcase
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_out();
    bit ev;
    ev = q.size() > 0 && q[0].age >= 2;
    chk("out_valid", W'(bus.out_valid), W'(ev));
    if (ev) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_zero", W'(bus.out_zero), W'(q[0].d == '0));
      chk("out_ones", W'(bus.out_ones), W'(&q[0].d));
      chk("out_par", W'(bus.out_par), W'(^q[0].d));
    end
    chk("acc_q", dut.acc_q, macc);
  endtask

  // One clock: drive, check in_ready, advance model, check outputs.
  task automatic step(bit v, logic [W-1:0] a, logic [W-1:0] b,
                      logic [2:0] op, bit acc, bit clr, bit ordy,
                      output bit ok);
    bit           er;
    logic [W-1:0] r;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.in_acc    = acc;
    bus.acc_clr   = clr;
    bus.out_ready = ordy;
    #1;
    er = (q.size() < 2) || ordy;
    chk("in_ready", W'(bus.in_ready), W'(er));
    if (bus.out_valid && ordy) got.push_back(bus.out_data);
    @(posedge clk);
    ok = v && er;
    r  = gate(op, a, acc ? macc : b);
    if (q.size() > 0 && q[0].age >= 2 && ordy) q.delete(0);
    foreach (q[i]) q[i].age++;
    if (ok) q.push_back('{d: r, age: 1});
    if (clr) macc = '0;
    else if (ok && acc) macc = r;
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(int n, bit ordy);
    bit ok;
    for (int i = 0; i < n; i++) step(0, '0, '0, 3'd0, 0, 0, ordy, ok);
  endtask

  task automatic cmp_got(string tag, logic [W-1:0] exp[$]);
    chk({tag, "_cnt"}, W'(got.size()), W'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) chk(tag, got[i], exp[i]);
    end
    got.delete();
  endtask

  initial begin
    bit           ok;
    int           n;
    logic [W-1:0] exp[$];

    bus.in_valid  = 0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_acc    = 0;
    bus.acc_clr   = 0;
    bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", W'(bus.out_valid), '0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_zero", W'(bus.out_zero), '0);
    chk("rst_ones", W'(bus.out_ones), '0);
    chk("rst_par", W'(bus.out_par), '0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", W'(bus.in_ready), W'(1));

    // All eight functions back-to-back
    for (int op = 0; op < 8; op++)
      step(1, 8'hC3, 8'h5A, 3'(op), 0, 0, 1, ok);
    idle(3, 1);
    exp = '{8'h42, 8'hDB, 8'h24, 8'h3C,
            8'h99, 8'h66, 8'hBD, 8'hC3};
    cmp_got("ops", exp);

    // Accumulate chain
    step(0, '0, '0, 3'd0, 0, 1, 1, ok);
    step(1, 8'h01, 8'hAA, 3'd1, 1, 0, 1, ok);
    step(1, 8'h02, 8'hAA, 3'd1, 1, 0, 1, ok);
    step(1, 8'h80, 8'hAA, 3'd1, 1, 0, 1, ok);
    chk("acc_chain", dut.acc_q, 8'h83);
    step(1, 8'hFF, 8'h00, 3'd4, 1, 0, 1, ok);
    idle(3, 1);
    exp = '{8'h01, 8'h03, 8'h83, 8'h7C};
    cmp_got("acc", exp);

    // Backpressure: five PASS-A transactions
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, W'((n + 1) * 8'h11), '0, 3'd7, 0, 0, 0, ok);
      if (ok) n++;
    end
    chk("bp_accepts", W'(n), W'(2));
    chk("bp_hold", bus.out_data, 8'h11);
    for (int g = 0; g < 20 && n < 5; g++) begin
      step(1, W'((n + 1) * 8'h11), '0, 3'd7, 0, 0, 1, ok);
      if (ok) n++;
    end
    chk("bp_done", W'(n), W'(5));
    idle(4, 1);
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cmp_got("bp", exp);

    // Flag corner values
    step(1, 8'h00, 8'h00, 3'd6, 0, 0, 1, ok);
    step(1, 8'hF0, 8'h0F, 3'd0, 0, 0, 1, ok);
    chk("ones_flag", W'(bus.out_ones), W'(1));
    step(0, '0, '0, 3'd0, 0, 0, 1, ok);
    chk("zero_flag", W'(bus.out_zero), W'(1));
    idle(2, 1);
    exp = '{8'hFF, 8'h00};
    cmp_got("flags", exp);

    // Clear coincident with an accumulating accept
    step(0, '0, '0, 3'd0, 0, 1, 1, ok);
    step(1, 8'h0F, 8'h00, 3'd1, 1, 0, 1, ok);
    step(1, 8'hF0, 8'h00, 3'd4, 1, 1, 1, ok);
    chk("acc_clr", dut.acc_q, 8'h00);
    idle(3, 1);
    exp = '{8'h0F, 8'hFF};
    cmp_got("clr", exp);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
           3'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, ok);
    idle(4, 1);
    got.delete();

    // Asynchronous reset with both stages full
    step(1, 8'h5A, '0, 3'd7, 0, 0, 0, ok);
    step(1, 8'hA5, '0, 3'd7, 1, 0, 0, ok);
    step(1, 8'h3C, '0, 3'd7, 0, 0, 0, ok);
    chk("full_ready", W'(bus.in_ready), W'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(bus.out_valid), '0);
    chk("arst_data", bus.out_data, '0);
    chk("arst_zero", W'(bus.out_zero), '0);
    chk("arst_ones", W'(bus.out_ones), '0);
    chk("arst_par", W'(bus.out_par), '0);
    chk("arst_acc", dut.acc_q, '0);
    q.delete();
    macc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1);
    chk("stale_cnt", W'(got.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
